pool_accelerator: RTL and testbench
===================================

POOL_ACCELERATOR -- requirements
Module: pool_accelerator

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the signed two's-complement sample width.
REQ-002 The parameter WIN SHALL default to 4 and set the samples per pooling window (power of two, 2..64).
REQ-003 The parameter IDX_W SHALL default to $clog2(WIN) and set the width of the result index.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  0 = max pooling, 1 = average pooling; sampled only on the first sample of each window.
REQ-007 flush  input  1  synchronous discard of any partial window.
REQ-008 in_data  input  DATA_W  signed input sample.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 out_data  output  DATA_W  pooled result (signed).
REQ-012 out_index  output  IDX_W  in max mode, the position within the window of the selected sample; in average mode, 0.
REQ-013 out_valid  output  1  result is valid and held until accepted.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 A sample SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-017 A sample counter (0..WIN-1) SHALL increment on each accepted sample and wrap to 0 after the WIN-th sample.
REQ-018 The first sample of a window SHALL load the accumulator unconditionally and latch mode and index 0.
REQ-019 In max mode, a later sample SHALL replace the held value only if it is strictly greater under signed comparison; on ties the earliest position is kept.
REQ-020 In average mode, samples SHALL be summed in a DATA_W+IDX_W-bit signed accumulator with no overflow possible.
REQ-021 The average result SHALL be the sum arithmetically shifted right by IDX_W (floor toward negative infinity), truncated to DATA_W.
REQ-022 out_valid SHALL rise on the cycle after the WIN-th sample is accepted, with out_data and out_index stable until the out_valid && out_ready handshake.
REQ-023 Latency from the last accepted sample to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be one sample per cycle while out_ready is held at 1.
REQ-024 On a cycle where the output handshakes and a new first sample is accepted, out_valid SHALL fall and the new window SHALL begin with no bubble.
REQ-025 If a window completes on the same cycle that the previous result handshakes, out_valid SHALL remain 1 and present the new result.
REQ-026 State machine: ACCUM (collecting, out_valid=0) -> FULL (result held, out_valid=1) on the WIN-th accept; FULL -> ACCUM on handshake; FULL -> FULL on handshake coincident with a window completion (WIN=1 is not permitted).
REQ-027 flush SHALL clear the counter and accumulator in ACCUM; in FULL it SHALL leave the held result intact and only reset the counter.
REQ-028 Changes on mode mid-window SHALL be ignored until the next window's first sample.

Reset
REQ-029 Asserting reset SHALL immediately force out_valid=0, out_data=0, out_index=0, the counter=0, the accumulator=0, latched mode=0, and state=ACCUM, regardless of clk.
REQ-030 Reset asserted mid-window SHALL discard the partial window; the first sample after release starts a new window.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts (absent flush).

Structure
REQ-032 A shared package pool_pkg SHALL hold the mode encoding constants (POOL_MAX=0, POOL_AVG=1) and the state encoding.
REQ-033 The signed compare-and-select SHALL be one sub-module, pool_cmp (inputs: candidate, held value; output: take-candidate flag).
REQ-034 No other sub-modules; the counter, accumulator and FSM reside in pool_accelerator.

Verification
REQ-035 Max mode with WIN=4, out_ready=1, samples 5, -3, 9, 9 -> out_data=9 and out_index=2 one cycle after the 4th accept.
REQ-036 Max mode with all negative samples -7, -2, -8, -2 -> out_data=-2 and out_index=1; with mixed samples -1, 3 (first two of window) -> 3 is held.
REQ-037 Average mode with samples -1, -2, -2, 0 (sum -5) -> out_data=-2 (floor); with samples 0x7FFFFFFF x4 -> out_data=0x7FFFFFFF (no overflow).
REQ-038 out_ready=0 for 5 cycles after out_valid -> in_ready=0, out_data stable; after out_ready=1, streaming of the next window continues with no bubble cycle.
REQ-039 Reset asserted asynchronously after 2 samples -> outputs clear immediately; the next 4 samples form a complete window.
REQ-040 flush after 3 samples, then samples 1, 2, 3, 4 in max mode -> out_data=4, out_index=3; mode toggled mid-window has no effect on the result.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared encodings for the pooling accelerator: pooling mode and FSM state.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_cmp.sv
// Signed compare-and-select: flags when the candidate strictly beats the held value.
module pool_cmp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] cand,
  input  logic signed [DATA_W-1:0] held,
  output logic                     take_c
);

  // Strict compare keeps the earliest position on ties.
  assign take_c = cand > held;

endmodule

// File: rtl/pool_accelerator.sv
// Streaming max/average pooling over fixed windows of WIN signed samples,
// with a one-deep registered result and valid/ready handshakes on both sides.
module pool_accelerator
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WIN    = 4,
  parameter int unsigned IDX_W  = $clog2(WIN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned ACC_W = DATA_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WIN - 1);

  pool_state_e              state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     mode_q, mode_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_index_q, out_index_d;

  logic                     accept, hs, first, last, take;
  logic signed [ACC_W-1:0]  in_ext, sum;
  logic signed [DATA_W-1:0] held;

  assign in_ready  = (state_q != ST_FULL || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign hs        = (state_q == ST_FULL) && out_ready;
  assign first     = (cnt_q == '0);
  assign last      = (cnt_q == LAST_CNT);
  assign in_ext    = {{IDX_W{in_data[DATA_W-1]}}, in_data};
  assign sum       = acc_q + in_ext;
  assign held      = acc_q[DATA_W-1:0];

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

  pool_cmp #(.DATA_W(DATA_W)) u_cmp (
    .cand   (in_data),
    .held   (held),
    .take_c (take)
  );

  // Window accumulation, result capture and ACCUM/FULL sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    if (hs) state_d = ST_ACCUM;

    if (flush) begin
      cnt_d = '0;
      if (state_q == ST_ACCUM) begin
        acc_d = '0;
        idx_d = '0;
      end
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + IDX_W'(1);
      if (first) begin
        acc_d  = in_ext;
        idx_d  = '0;
        mode_d = mode;
      end else if (mode_q == POOL_AVG) begin
        acc_d = sum;
      end else if (take) begin
        acc_d = in_ext;
        idx_d = cnt_q;
      end

      // Window completes: the last sample never coincides with the first.
      if (last) begin
        state_d = ST_FULL;
        if (mode_q == POOL_AVG) begin
          out_data_d  = DATA_W'(sum >>> IDX_W);
          out_index_d = '0;
        end else if (take) begin
          out_data_d  = in_data;
          out_index_d = cnt_q;
        end else begin
          out_data_d  = held;
          out_index_d = idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      mode_q      <= POOL_MAX;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

endmodule

// File: tb/tb_pool_accelerator.sv
// Directed bench for pool_accelerator: window-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_pool_accelerator;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WIN    = 4;
  localparam int unsigned IDX_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset, mode, flush, in_valid, out_ready;
  logic                     in_ready, out_valid;
  logic signed [DATA_W-1:0] in_data, out_data;
  logic [IDX_W-1:0]         out_index;

  int errors = 0;
  int checks = 0;

  pool_accelerator #(.DATA_W(DATA_W), .WIN(WIN), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pooled value of a complete window straight from the rules.
  function automatic void pool_result(input int s[$], input logic m,
                                      output logic signed [31:0] d, output int idx);
    longint sum, q, w;
    w = 4;
    d = s[0];
    idx = 0;
    if (m == 1'b0) begin
      for (int i = 1; i < s.size(); i++)
        if (s[i] > d) begin
          d = s[i];
          idx = i;
        end
    end else begin
      sum = 0;
      foreach (s[i]) sum += longint'(s[i]);
      q = sum / w;
      if (sum < 0 && (sum % w) != 0) q = q - 1;
      d = q[31:0];
    end
  endfunction

  int                 win_q[$];
  logic               win_mode;
  logic               exp_valid = 1'b0;
  logic signed [31:0] exp_data = '0;
  int                 exp_idx = 0;
  logic               m_rdy;

  // Per-cycle compare, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      win_q.delete();
      exp_valid = 1'b0;
    end else begin
      m_rdy = (!exp_valid || out_ready) && !flush;
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_data", out_data, exp_data);
        chk("out_index", out_index, exp_idx);
      end
      if (flush) begin
        win_q.delete();
        if (exp_valid && out_ready) exp_valid = 1'b0;
      end else if (in_valid && m_rdy) begin
        if (win_q.size() == 0) win_mode = mode;
        win_q.push_back(int'(in_data));
        if (win_q.size() == WIN) begin
          pool_result(win_q, win_mode, exp_data, exp_idx);
          exp_valid = 1'b1;
          win_q.delete();
        end else if (exp_valid && out_ready) begin
          exp_valid = 1'b0;
        end
      end else if (exp_valid && out_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Max mode, tie keeps earliest index
    mode = 1'b0;
    send(5); send(-3); send(9); send(9);
    chk("max_basic_valid", out_valid, 1);
    chk("max_basic_data", out_data, 9);
    chk("max_basic_idx", out_index, 2);

    send(-7); send(-2); send(-8); send(-2);
    chk("max_neg_data", out_data, -2);
    chk("max_neg_idx", out_index, 1);

    send(-1); send(3); send(0); send(1);
    chk("max_mixed_data", out_data, 3);
    chk("max_mixed_idx", out_index, 1);

    // Average mode: floor rounding and wide accumulator
    mode = 1'b1;
    send(-1); send(-2); send(-2); send(0);
    chk("avg_floor_data", out_data, -2);
    chk("avg_floor_idx", out_index, 0);
    send(32'h7FFF_FFFF); send(32'h7FFF_FFFF); send(32'h7FFF_FFFF); send(32'h7FFF_FFFF);
    chk("avg_big_data", out_data, 32'sh7FFF_FFFF);

    // Backpressure holds the result, then streaming resumes with no bubble
    mode = 1'b0;
    send(1); send(8); send(2); send(3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data", out_data, 8);
    end
    out_ready = 1'b1;
    send(10);
    chk("bp_release_valid", out_valid, 0);
    send(20); send(30); send(40);
    chk("bp_next_data", out_data, 40);
    chk("bp_next_idx", out_index, 3);

    // Asynchronous reset mid-window
    send(6); send(7);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_idx", out_index, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(2); send(5); send(1); send(5);
    chk("after_rst_data", out_data, 5);
    chk("after_rst_idx", out_index, 1);

    // Flush a partial average window; mode wiggles mid-window are ignored
    mode = 1'b1;
    send(100); send(100); send(100);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 50;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    mode = 1'b0; send(1);
    mode = 1'b1; send(2);
    mode = 1'b0; send(3);
    mode = 1'b1; send(4);
    chk("flush_max_data", out_data, 4);
    chk("flush_max_idx", out_index, 3);

    // Flush while a result is held leaves it intact
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_full_valid", out_valid, 1);
    chk("flush_full_data", out_data, 4);
    out_ready = 1'b1;
    idle();
    chk("drain_valid", out_valid, 0);

    mode = 1'b1;
    send(3); send(4); send(-5); send(-9);
    chk("avg_mixed_data", out_data, -2);

    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
